ft_recovery_sequencer: RTL and testbench
========================================

Name: ft_recovery_sequencer

Overview:
- Sequences rollback recovery for the lockstep fault-tolerance datapath.
- On a comparator mismatch it halts both cores' fetch and waits for them to drain.
- It then replays every checkpointed register from the safe GPR into both cores' register files, restores the PC from the safe PC register, and resumes execution.
- Sits between the comparator error output, the safe GPR read port, the safe PC load control and the cores' fetch/RF write ports.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.
- NUM_REGS, 32, number of registers replayed (addresses 0..NUM_REGS-1); must be <= 2**ADDR_WIDTH.
- DRAIN_TIMEOUT, 16, maximum cycles to wait for halt_ack_i before proceeding anyway; must be >= 1.
- MAX_RECOVERY, 7, recovery count that triggers the fatal state (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- error_i  in  1  comparator mismatch flag.
- halt_ack_i  in  1  both cores drained and idle.
- sgpr_raddr_o  out  ADDR_WIDTH  safe GPR read address.
- sgpr_rdata_i  in  DATA_WIDTH  safe GPR read data; combinational w.r.t. sgpr_raddr_o.
- rf_we_o  out  1  core RF write enable (both cores).
- rf_waddr_o  out  ADDR_WIDTH  core RF write address.
- rf_wdata_o  out  DATA_WIDTH  core RF write data.
- spc_load_o  out  1  one-cycle pulse: cores load PC from the safe PC.
- halt_o  out  1  fetch block.
- resume_o  out  1  one-cycle resume pulse.
- busy_o  out  1  recovery in progress (state != IDLE).
- fatal_o  out  1  unrecoverable; tied 0 when the optional feature is compiled out.

Behaviour:
- All outputs are registered. Reset (asynchronous, any state) forces state IDLE, all outputs 0, replay counter 0, drain counter 0.
- States: IDLE, DRAIN, REPLAY, RESTORE, RESUME (plus FATAL with the optional feature).
- IDLE:
  - error_i=1 sampled -> DRAIN next cycle.
  - halt_o and busy_o rise in that same next cycle, i.e. 1-cycle latency from error_i to halt_o.
- DRAIN:
  - halt_o=1. Drain counter increments each cycle.
  - Exit to REPLAY when halt_ack_i=1, or when the counter reaches DRAIN_TIMEOUT-1 (whichever comes first).
  - Replay counter is cleared on entry.
- REPLAY:
  - Each cycle: sgpr_raddr_o = counter; rf_we_o=1; rf_waddr_o = counter; rf_wdata_o = sgpr_rdata_i registered alongside.
  - The write therefore appears one cycle after the read address.
  - After address NUM_REGS-1 is written -> RESTORE.
  - Exactly NUM_REGS write cycles, addresses strictly ascending, no wrap past NUM_REGS-1.
  - rf_we_o=0 in every other state.
- RESTORE: spc_load_o=1 for exactly one cycle -> RESUME.
- RESUME: resume_o=1 and halt_o=0 for exactly one cycle -> IDLE; busy_o falls on entry to IDLE.
- error_i in DRAIN/REPLAY/RESTORE/RESUME is ignored; the cores are halted and comparator data is invalid.
- error_i held high on the first IDLE cycle after RESUME starts a new recovery immediately, with no idle gap required.
- halt_ack_i is ignored outside DRAIN.
- sgpr_raddr_o holds 0 outside REPLAY.

Optional Feature:
- Macro: FT_RECOVERY_LIMIT_EN.
- Compiled in:
  - Saturating counter of width $clog2(MAX_RECOVERY+1), incremented on each IDLE->DRAIN transition.
  - If error_i is sampled in IDLE while the counter already equals MAX_RECOVERY, the block enters FATAL instead of DRAIN.
  - FATAL: halt_o=1, fatal_o=1, busy_o=1, no replay. Left only by reset, which also clears the counter.
- Compiled out:
  - No counter; fatal_o is constant 0.
  - Recoveries are unlimited.

Test Plan:
- Reset then idle 10 cycles with error_i=0 -> all outputs 0, busy_o=0.
- error_i pulse at cycle t, halt_ack_i=1 at t+3, sgpr holding value 0x1000_0000+addr -> halt_o=1 from t+1; 32 rf_we_o cycles with waddr 0..31 and wdata 0x1000_0000..0x1000_001F; spc_load_o one cycle; resume_o one cycle with halt_o=0; busy_o=0 afterwards.
- halt_ack_i held 0, DRAIN_TIMEOUT=16 -> REPLAY starts exactly 16 cycles after entering DRAIN.
- error_i toggling throughout REPLAY -> replay sequence identical to the clean run, single resume_o; error_i held high after RESUME -> new halt_o on the following cycle.
- rst_n asserted asynchronously mid-REPLAY (address 12) -> all outputs 0 immediately; after release, idle until the next error_i.
- FT_RECOVERY_LIMIT_EN, MAX_RECOVERY=2: three error events -> two full recoveries, then the third yields halt_o=1, fatal_o=1 indefinitely with no rf_we_o; reset clears it.

Source files
------------

// File: rtl/ft_recovery_sequencer.sv
// Rollback recovery sequencer for the lockstep pair: halt, drain, replay safe GPRs, restore PC, resume.
// Optional recovery limit with a sticky fatal state is compiled in with FT_RECOVERY_LIMIT_EN.
//
// state   | meaning
// IDLE    | normal execution, watching error_i
// DRAIN   | fetch halted, waiting for halt_ack_i or drain timeout
// REPLAY  | one safe-GPR write per cycle into both core RFs
// RESTORE | one-cycle safe PC load
// RESUME  | one-cycle resume pulse, fetch released
// FATAL   | recovery limit exceeded, halted until reset (limit build only)
module ft_recovery_sequencer #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 32,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int MAX_RECOVERY  = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  error_i,
    input  logic                  halt_ack_i,
    output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
    input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  spc_load_o,
    output logic                  halt_o,
    output logic                  resume_o,
    output logic                  busy_o,
    output logic                  fatal_o
);

    localparam int DCNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DCNT_W-1:0]     DRAIN_LAST     = DCNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR      = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_PREFETCH = ADDR_WIDTH'((NUM_REGS > 1) ? 1 : 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_REPLAY  = 3'd2;
    localparam logic [2:0] S_RESTORE = 3'd3;
    localparam logic [2:0] S_RESUME  = 3'd4;
`ifdef FT_RECOVERY_LIMIT_EN
    localparam logic [2:0] S_FATAL   = 3'd5;
    localparam int REC_W = $clog2(MAX_RECOVERY + 1);
    localparam logic [REC_W-1:0] REC_MAX = REC_W'(MAX_RECOVERY);
`endif

    if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_WIDTH) || DRAIN_TIMEOUT < 1 || MAX_RECOVERY < 1)
    begin : g_param_check
        $error("ft_recovery_sequencer: illegal parameter combination");
    end

    logic [2:0]            state_q,  state_d;
    logic [DCNT_W-1:0]     dcnt_q,   dcnt_d;
    logic [ADDR_WIDTH-1:0] rcnt_q,   rcnt_d;
    logic [ADDR_WIDTH-1:0] raddr_q,  raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic                  we_q,     we_d;
    logic                  halt_q,   halt_d;
    logic                  busy_q,   busy_d;
    logic                  spc_q,    spc_d;
    logic                  resume_q, resume_d;
`ifdef FT_RECOVERY_LIMIT_EN
    logic [REC_W-1:0]      rec_q,    rec_d;
    logic                  fatal_q,  fatal_d;
`endif

    // The read port runs one address ahead of the write port: address 0 is read while
    // still in DRAIN (raddr idles at 0), so write k carries data fetched with address k.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        raddr_d = raddr_q;
        wdata_d = wdata_q;
`ifdef FT_RECOVERY_LIMIT_EN
        rec_d   = rec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (error_i) begin
                    dcnt_d = '0;
                    rcnt_d = '0;
`ifdef FT_RECOVERY_LIMIT_EN
                    if (rec_q == REC_MAX) begin
                        state_d = S_FATAL;
                    end else begin
                        state_d = S_DRAIN;
                        rec_d   = rec_q + 1'b1;
                    end
`else
                    state_d = S_DRAIN;
`endif
                end
            end
            S_DRAIN: begin
                if (halt_ack_i || dcnt_q == DRAIN_LAST) begin
                    state_d = S_REPLAY;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                    wdata_d = sgpr_rdata_i;
                    raddr_d = FIRST_PREFETCH;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_REPLAY: begin
                if (rcnt_q == LAST_ADDR) begin
                    state_d = S_RESTORE;
                    rcnt_d  = '0;
                    raddr_d = '0;
                    wdata_d = '0;
                end else begin
                    rcnt_d  = rcnt_q + 1'b1;
                    wdata_d = sgpr_rdata_i;
                    raddr_d = (rcnt_q + 1'b1 == LAST_ADDR) ? '0 : raddr_q + 1'b1;
                end
            end
            S_RESTORE: state_d = S_RESUME;
            S_RESUME:  state_d = S_IDLE;
`ifdef FT_RECOVERY_LIMIT_EN
            S_FATAL:   state_d = S_FATAL;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    // Output flops are decoded from the next state so they line up with state_q.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        halt_d   = (state_d != S_IDLE) && (state_d != S_RESUME);
        we_d     = (state_d == S_REPLAY);
        spc_d    = (state_d == S_RESTORE);
        resume_d = (state_d == S_RESUME);
`ifdef FT_RECOVERY_LIMIT_EN
        fatal_d  = (state_d == S_FATAL);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dcnt_q   <= '0;
            rcnt_q   <= '0;
            raddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            halt_q   <= 1'b0;
            busy_q   <= 1'b0;
            spc_q    <= 1'b0;
            resume_q <= 1'b0;
`ifdef FT_RECOVERY_LIMIT_EN
            rec_q    <= '0;
            fatal_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            rcnt_q   <= rcnt_d;
            raddr_q  <= raddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            halt_q   <= halt_d;
            busy_q   <= busy_d;
            spc_q    <= spc_d;
            resume_q <= resume_d;
`ifdef FT_RECOVERY_LIMIT_EN
            rec_q    <= rec_d;
            fatal_q  <= fatal_d;
`endif
        end
    end

    assign sgpr_raddr_o = raddr_q;
    assign rf_we_o      = we_q;
    assign rf_waddr_o   = rcnt_q;
    assign rf_wdata_o   = wdata_q;
    assign spc_load_o   = spc_q;
    assign halt_o       = halt_q;
    assign resume_o     = resume_q;
    assign busy_o       = busy_q;
`ifdef FT_RECOVERY_LIMIT_EN
    assign fatal_o      = fatal_q;
`else
    assign fatal_o      = 1'b0;
`endif

endmodule

// File: tb/tb_ft_recovery_sequencer.sv
// Scoreboard bench for ft_recovery_sequencer: a timeline model queues the expected output
// cycles of each recovery, and a negedge monitor pops and compares whatever the DUT presents.
module tb_ft_recovery_sequencer;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int DT = 16;
    localparam int MAXR = 2;
    localparam int FATAL_HOLD = 20;
`ifdef FT_RECOVERY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          error_i = 1'b0;
    logic          halt_ack_i = 1'b0;
    logic [AW-1:0] sgpr_raddr_o;
    logic [DW-1:0] sgpr_rdata_i;
    logic          rf_we_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic          spc_load_o, halt_o, resume_o, busy_o, fatal_o;

    logic [DW-1:0] mem [NR];
    assign sgpr_rdata_i = mem[sgpr_raddr_o];

    ft_recovery_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .DRAIN_TIMEOUT(DT), .MAX_RECOVERY(MAXR)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .error_i(error_i), .halt_ack_i(halt_ack_i),
        .sgpr_raddr_o(sgpr_raddr_o), .sgpr_rdata_i(sgpr_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .spc_load_o(spc_load_o), .halt_o(halt_o), .resume_o(resume_o),
        .busy_o(busy_o), .fatal_o(fatal_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct packed {
        logic          halt;
        logic          busy;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          spc;
        logic          resume;
        logic          fatal;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   rec_since_rst = 0;

    function automatic obs_t mk(input logic h, input logic b, input logic w, input int a,
                                input logic [DW-1:0] d, input logic s, input logic r,
                                input logic f);
        obs_t o;
        o.halt = h; o.busy = b; o.we = w; o.waddr = AW'(a); o.wdata = d;
        o.spc = s; o.resume = r; o.fatal = f;
        return o;
    endfunction

    task automatic push(input int c, input obs_t o);
        exp_t e;
        e.cyc = c;
        e.o = o;
        expq.push_back(e);
    endtask

    always @(negedge clk_i) begin : monitor
        obs_t act;
        exp_t e;
        act.halt = halt_o; act.busy = busy_o; act.we = rf_we_o;
        act.waddr = rf_we_o ? rf_waddr_o : '0;
        act.wdata = rf_we_o ? rf_wdata_o : '0;
        act.spc = spc_load_o; act.resume = resume_o; act.fatal = fatal_o;
        if (act != '0) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d got=%h", cyc, act);
            end else begin
                e = expq.pop_front();
                if (e.cyc != cyc || e.o != act) begin
                    errors++;
                    $display("FAIL out_seq cyc=%0d got=%h expected cyc=%0d val=%h",
                             cyc, act, e.cyc, e.o);
                end
            end
        end else begin
            if (expq.size() != 0 && expq[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_output cyc=%0d got=%h expected val=%h", cyc, act, expq[0].o);
                void'(expq.pop_front());
            end
            checks++;
            if (sgpr_raddr_o != '0) begin
                errors++;
                $display("FAIL idle_raddr cyc=%0d got=%0d expected=0", cyc, sgpr_raddr_o);
            end
        end
    end

    // Called a little after a negedge; returns at a negedge with reset released.
    task automatic do_reset();
        int c;
        #1;
        rst_n = 1'b0;
        c = cyc;
        while (expq.size() != 0 && expq[$].cyc > c) void'(expq.pop_back());
        #1;
        checks++;
        if ({halt_o, busy_o, rf_we_o, spc_load_o, resume_o, fatal_o} != 6'b0 ||
            sgpr_raddr_o != '0 || rf_waddr_o != '0 || rf_wdata_o != '0) begin
            errors++;
            $display("FAIL reset_outputs got halt=%b busy=%b we=%b spc=%b res=%b fat=%b raddr=%0d waddr=%0d wdata=%h expected all 0",
                     halt_o, busy_o, rf_we_o, spc_load_o, resume_o, fatal_o,
                     sgpr_raddr_o, rf_waddr_o, rf_wdata_o);
        end
        rec_since_rst = 0;
        error_i = 1'b0;
        halt_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
    endtask

    // Start at a negedge with the DUT idle. a = drain cycle index at which halt_ack_i
    // rises; rst_at >= 0 resets the DUT while that replay address is being written.
    task automatic recover(input int a, input bit noise, input int rst_at);
        int t, d;
        t = cyc;
        error_i = 1'b1;
        halt_ack_i = noise ? 1'($urandom) : 1'b0;
        if (LIMIT_EN && rec_since_rst == MAXR) begin
            for (int k = 1; k <= FATAL_HOLD; k++) push(t + k, mk(1, 1, 0, 0, '0, 0, 0, 1));
            for (int k = 1; k <= FATAL_HOLD; k++) begin
                @(negedge clk_i);
                error_i = noise ? 1'($urandom) : 1'b0;
                halt_ack_i = 1'($urandom);
            end
            do_reset();
            return;
        end
        rec_since_rst++;
        d = ((a < DT - 1) ? a : DT - 1) + 1;
        for (int j = 0; j < d; j++) push(t + 1 + j, mk(1, 1, 0, 0, '0, 0, 0, 0));
        for (int i = 0; i < NR; i++) push(t + 1 + d + i, mk(1, 1, 1, i, mem[i], 0, 0, 0));
        push(t + 1 + d + NR, mk(1, 1, 0, 0, '0, 1, 0, 0));
        push(t + 2 + d + NR, mk(0, 1, 0, 0, '0, 0, 1, 0));
        for (int x = t + 1; x <= t + d + NR + 2; x++) begin
            @(negedge clk_i);
            error_i = noise ? 1'($urandom) : 1'b0;
            if (x <= t + d) halt_ack_i = (x - t - 1 >= a);
            else            halt_ack_i = noise ? 1'($urandom) : 1'b0;
            if (rst_at >= 0 && x == t + 1 + d + rst_at) begin
                #1;
                checks++;
                if (!(rf_we_o && rf_waddr_o == AW'(rst_at))) begin
                    errors++;
                    $display("FAIL reset_point got we=%b waddr=%0d expected we=1 waddr=%0d",
                             rf_we_o, rf_waddr_o, rst_at);
                end
                do_reset();
                return;
            end
        end
        @(negedge clk_i);
        error_i = 1'b0;
        halt_ack_i = 1'b0;
    endtask

    task automatic fill_mem(input bit directed);
        for (int i = 0; i < NR; i++) mem[i] = directed ? (32'h1000_0000 + 32'(i)) : $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fill_mem(1'b1);
        do_reset();
        repeat (10) @(negedge clk_i);

        recover(2, 1'b0, -1);
        repeat (3) @(negedge clk_i);
        recover(100, 1'b0, -1);
        repeat (2) @(negedge clk_i);
        if (LIMIT_EN) do_reset();

        fill_mem(1'b0);
        recover($urandom_range(0, 5), 1'b1, -1);
        recover(1, 1'b0, -1);
        if (LIMIT_EN) do_reset();

        fill_mem(1'b1);
        recover(3, 1'b0, 12);
        repeat (5) @(negedge clk_i);

        for (int n = 0; n < 12; n++) begin
            if (LIMIT_EN && rec_since_rst == MAXR) do_reset();
            fill_mem(1'b0);
            recover($urandom_range(0, 20), 1'($urandom), -1);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end

`ifdef FT_RECOVERY_LIMIT_EN
        do_reset();
        fill_mem(1'b1);
        recover(2, 1'b0, -1);
        recover(4, 1'b0, -1);
        recover(0, 1'b0, -1);
        fill_mem(1'b0);
        recover(1, 1'b0, -1);
`endif

        repeat (5) @(negedge clk_i);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d pending entries expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
